// File: rtl/uart_pkg.sv
// uart_pkg: shared receiver/transmitter state encoding and bit-timing derivation.
package uart_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

    function automatic int cycle_of(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

    function automatic int half_of(input int clk_freq, input int baud);
        return (clk_freq / baud) / 2;
    endfunction
endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchronizer for the serial line plus falling-edge detect.
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic rx_pin,
    output logic rx_s,
    output logic fall
);
    logic s1, prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) {s1, rx_s, prev} <= 3'b111;
        else        {s1, rx_s, prev} <= {rx_pin, s1, rx_s};
    end

    assign fall = prev & ~rx_s;
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 LSB-first receiver; samples start at mid-bit then every full bit period.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 27_000_000,
    parameter int BOUD_RATE = 9600
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_pin,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);
    localparam int CYCLE = cycle_of(CLK_FREQ, BOUD_RATE);
    localparam int HALF  = half_of(CLK_FREQ, BOUD_RATE);
    localparam int CW    = $clog2(CYCLE);

    state_t          state, state_n;
    logic [CW-1:0]   count, count_n;
    logic [2:0]      idx, idx_n;
    logic [7:0]      shift, shift_n, data_n;
    logic            valid_n, ferr_n, rx_s, fall, tick_half, tick_full;

    uart_rx_sync u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .rx_pin (rx_pin),
        .rx_s   (rx_s),
        .fall   (fall)
    );

    assign tick_half = count == CW'(HALF - 1);
    assign tick_full = count == CW'(CYCLE - 1);
    assign busy      = state != IDLE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            count     <= '0;
            idx       <= '0;
            shift     <= '0;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_n;
            count     <= count_n;
            idx       <= idx_n;
            shift     <= shift_n;
            data      <= data_n;
            valid     <= valid_n;
            frame_err <= ferr_n;
        end
    end

    always_comb begin
        state_n = state;
        count_n = count + CW'(1);
        idx_n   = idx;
        shift_n = shift;
        data_n  = data;
        valid_n = 1'b0;
        ferr_n  = 1'b0;
        unique case (state)
            IDLE: begin
                count_n = '0;
                if (fall) state_n = START;
            end
            START: if (tick_half) begin
                // a high line at mid-start was only a glitch
                state_n = rx_s ? IDLE : DATA;
                idx_n   = '0;
                count_n = '0;
            end
            DATA: if (tick_full) begin
                shift_n = {rx_s, shift[7:1]};
                idx_n   = idx + 3'd1;
                count_n = '0;
                if (idx == 3'd7) state_n = STOP;
            end
            STOP: if (tick_full) begin
                count_n = '0;
                if (rx_s) begin
                    data_n  = shift;
                    valid_n = 1'b1;
                    state_n = IDLE;
                end else begin
                    ferr_n  = 1'b1;
                    state_n = WAIT_HIGH;
                end
            end
            WAIT_HIGH: begin
                count_n = '0;
                if (rx_s) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end
endmodule
